// File: rtl/apple_iie_timing_gen.sv
// Apple IIe master timing: CPU phases, Q3, 7M enable and video H/V counters from clk_14M.
// Optional `TIMING_FREEZE_EN adds a freeze input that parks the sequencer at the last tick of a cycle.
module apple_iie_timing_gen #(
  parameter int LINES_PER_FRAME = 262,
  parameter int HBL_END         = 25,
  parameter int VBL_START       = 192
) (
  input  logic       clk_14M,
  input  logic       reset,
`ifdef TIMING_FREEZE_EN
  input  logic       freeze,
`endif
  output logic       phi0,
  output logic       cycle_start,
  output logic       phi1_start,
  output logic       q3,
  output logic       clk7_en,
  output logic       long_cycle,
  output logic [6:0] h_count,
  output logic [8:0] v_count,
  output logic       hbl,
  output logic       vbl
);

  logic [3:0] t_q, t_d;
  logic [6:0] h_q, h_d;
  logic [8:0] v_q, v_d;

  logic       phi0_q, cycle_start_q, phi1_start_q, q3_q, clk7_en_q, long_cycle_q;
  logic       hbl_q, vbl_q;
  logic [6:0] h_count_q;
  logic [8:0] v_count_q;

  logic       long_w;
  logic       at_last;
  logic       hold;

  assign long_w  = (h_q == 7'd64);
  assign at_last = long_w ? (t_q == 4'd15) : (t_q == 4'd13);

`ifdef TIMING_FREEZE_EN
  assign hold = at_last & freeze;
`else
  assign hold = 1'b0;
`endif

  // H/V wraps all land on the edge that ends the stretched 65th cycle.
  always_comb begin
    t_d = t_q + 4'd1;
    h_d = h_q;
    v_d = v_q;
    if (hold) begin
      t_d = t_q;
    end else if (at_last) begin
      t_d = 4'd0;
      if (long_w) begin
        h_d = 7'd0;
        if (v_q == 9'(LINES_PER_FRAME - 1)) v_d = 9'd0;
        else                                 v_d = v_q + 9'd1;
      end else begin
        h_d = h_q + 7'd1;
      end
    end
  end

  // Outputs decode the pre-edge t/h/v, giving one tick of latency.
  always_ff @(posedge clk_14M or negedge reset) begin
    if (!reset) begin
      t_q           <= 4'd0;
      h_q           <= 7'd0;
      v_q           <= 9'd0;
      phi0_q        <= 1'b0;
      cycle_start_q <= 1'b0;
      phi1_start_q  <= 1'b0;
      q3_q          <= 1'b0;
      clk7_en_q     <= 1'b0;
      long_cycle_q  <= 1'b0;
      h_count_q     <= 7'd0;
      v_count_q     <= 9'd0;
      hbl_q         <= 1'b1;
      vbl_q         <= 1'b0;
    end else begin
      t_q           <= t_d;
      h_q           <= h_d;
      v_q           <= v_d;
      phi0_q        <= (t_q <= 4'd6);
      cycle_start_q <= (t_q == 4'd0);
      phi1_start_q  <= (t_q == 4'd7);
      q3_q          <= (t_q <= 4'd3) || ((t_q >= 4'd7) && (t_q <= 4'd10));
      // Every cycle length is even, so a free toggle equals ~t[0] and keeps running while frozen.
      clk7_en_q     <= ~clk7_en_q;
      long_cycle_q  <= long_w;
      h_count_q     <= h_q;
      v_count_q     <= v_q;
      hbl_q         <= (h_q < 7'(HBL_END));
      vbl_q         <= (v_q >= 9'(VBL_START));
    end
  end

  assign phi0        = phi0_q;
  assign cycle_start = cycle_start_q;
  assign phi1_start  = phi1_start_q;
  assign q3          = q3_q;
  assign clk7_en     = clk7_en_q;
  assign long_cycle  = long_cycle_q;
  assign h_count     = h_count_q;
  assign v_count     = v_count_q;
  assign hbl         = hbl_q;
  assign vbl         = vbl_q;

endmodule

// File: tb/tb_apple_iie_timing_gen.sv
// Directed bench for apple_iie_timing_gen, built with a short frame so a full frame wrap fits in the run.
module tb_apple_iie_timing_gen;

  localparam int LPF = 10;
  localparam int VBS = 6;
  localparam int HBE = 25;

  logic       clk_14M = 1'b0;
  logic       reset   = 1'b0;
  logic       freeze  = 1'b0;
  logic       phi0, cycle_start, phi1_start, q3, clk7_en, long_cycle, hbl, vbl;
  logic [6:0] h_count;
  logic [8:0] v_count;

  int total = 0;
  int bad   = 0;

  apple_iie_timing_gen #(
    .LINES_PER_FRAME(LPF),
    .HBL_END        (HBE),
    .VBL_START      (VBS)
  ) dut (
    .clk_14M    (clk_14M),
    .reset      (reset),
`ifdef TIMING_FREEZE_EN
    .freeze     (freeze),
`endif
    .phi0       (phi0),
    .cycle_start(cycle_start),
    .phi1_start (phi1_start),
    .q3         (q3),
    .clk7_en    (clk7_en),
    .long_cycle (long_cycle),
    .h_count    (h_count),
    .v_count    (v_count),
    .hbl        (hbl),
    .vbl        (vbl)
  );

  always #35 clk_14M = ~clk_14M;

  // {phi0, cycle_start, phi1_start, q3, clk7_en, long_cycle, hbl, vbl, h[6:0], v[8:0]}
  function automatic logic [23:0] obs_vec();
    return {phi0, cycle_start, phi1_start, q3, clk7_en, long_cycle, hbl, vbl, h_count, v_count};
  endfunction

  // Expected outputs after the (n+1)-th edge following reset release.
  function automatic logic [23:0] exp_vec(input int n);
    int line, p, h, t;
    logic e_phi0, e_cs, e_p1s, e_q3, e_c7, e_long, e_hbl, e_vbl;
    line = (n / 912) % LPF;
    p    = n % 912;
    if (p < 896) begin
      h = p / 14;
      t = p % 14;
    end else begin
      h = 64;
      t = p - 896;
    end
    e_phi0 = (t < 7);
    e_cs   = (t == 0);
    e_p1s  = (t == 7);
    e_q3   = (t <= 3) || (t >= 7 && t <= 10);
    e_c7   = ((t % 2) == 0);
    e_long = (h == 64);
    e_hbl  = (h < HBE);
    e_vbl  = (line >= VBS);
    return {e_phi0, e_cs, e_p1s, e_q3, e_c7, e_long, e_hbl, e_vbl, 7'(h), 9'(line)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_14M);
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk_14M);
    reset = 1'b1;
  endtask

  localparam logic [23:0] RST_VEC = {8'b0000_0010, 7'd0, 9'd0};

  initial begin
    int cs_count;
    int phi0_low_long;
    logic prev_c7;
    bit seen;

    // Reset state
    reset = 1'b0;
    repeat (3) tick();
    chk("reset_state", 32'(obs_vec()), 32'(RST_VEC));

    // Full frame plus a few cycles, every tick compared against the position model
    release_reset();
    cs_count      = 0;
    phi0_low_long = 0;
    for (int n = 0; n < LPF * 912 + 20; n++) begin
      tick();
      chk($sformatf("frame_n%0d", n), 32'(obs_vec()), 32'(exp_vec(n)));
      if (n < 912 && cycle_start) cs_count++;
      if (n >= 896 && n < 912 && !phi0) phi0_low_long++;
    end
    chk("cs_per_line", 32'(cs_count), 32'd65);
    chk("long_phi1_len", 32'(phi0_low_long), 32'd9);

    // Async reset mid-cycle at h=30, t=5
    reset = 1'b0;
    #5;
    release_reset();
    repeat (30 * 14 + 5 + 1) tick();
    chk("pre_reset_h30_t5", 32'(obs_vec()), 32'(exp_vec(30 * 14 + 5)));
    #3 reset = 1'b0;
    #1;
    chk("async_reset_vals", 32'(obs_vec()), 32'(RST_VEC));
    release_reset();
    #1;
    chk("held_until_edge", 32'(obs_vec()), 32'(RST_VEC));
    tick();
    chk("first_after_reset", 32'(obs_vec()), 32'(exp_vec(0)));
    tick();
    chk("second_after_reset", 32'(obs_vec()), 32'(exp_vec(1)));

`ifdef TIMING_FREEZE_EN
    reset = 1'b0;
    #5;
    release_reset();
    repeat (4) tick();
    chk("frz_at_t3", 32'(obs_vec()), 32'(exp_vec(3)));
    freeze  = 1'b1;
    prev_c7 = clk7_en;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (i < 10) begin
        chk($sformatf("frz_finish_%0d", i), 32'(obs_vec()), 32'(exp_vec(4 + i)));
      end else begin
        chk($sformatf("frz_hold_%0d", i),
            32'({phi0, cycle_start, phi1_start, q3, h_count}), 32'({4'b0000, 7'd0}));
      end
      chk($sformatf("frz_c7_%0d", i), 32'(clk7_en), 32'(~prev_c7));
      prev_c7 = clk7_en;
    end
    freeze = 1'b0;
    seen   = 1'b0;
    for (int i = 0; i < 3 && !seen; i++) begin
      tick();
      if (cycle_start) seen = 1'b1;
    end
    chk("frz_resume_cs", 32'(seen), 32'd1);
    chk("frz_resume_h", 32'(h_count), 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
